unidade_controle: RTL

- Multi-cycle control FSM for the RISC-V datapath.
- Generates the 3-bit `estado` consumed by the fetch, decode, execute, memory and writeback stages.
- Drives all datapath enables from the decoded `opcode`/`funct3`, the ALU `zero` flag and a memory ready handshake.
- Counts retired instructions and traps on illegal opcodes or memory timeouts.

---
 rtl/unidade_controle.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the RISC-V datapath: sequences fetch/decode/execute/
// memory/writeback, decodes datapath enables, counts retired instructions and traps.
module unidade_controle #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       estado,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] instr_count,
  output logic             erro
);

  typedef enum logic [2:0] {
    BUSCA      = 3'b000,
    DECODIFICA = 3'b001,
    EXECUTA    = 3'b010,
    MEMORIA    = 3'b011,
    ESCRITA    = 3'b100,
    ERRO       = 3'b111
  } estado_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  estado_t            estado_q, estado_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               erro_q, erro_d;
  logic               retire_s;
  logic               waiting_s;

  // beq taken on zero, bne taken on not-zero; other compares are not supported
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    estado_d   = estado_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    retire_s   = 1'b0;
    waiting_s  = 1'b0;
    case (estado_q)
      BUSCA: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          estado_d = DECODIFICA;
        end else begin
          waiting_s = 1'b1;
          estado_d  = (wait_q == WAIT_LAST) ? ERRO : BUSCA;
        end
      end
      DECODIFICA: estado_d = EXECUTA;
      EXECUTA: begin
        case (opcode)
          OP_R: begin
            alu_op   = 2'b10;
            estado_d = ESCRITA;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            estado_d  = MEMORIA;
          end
          OP_BRANCH: begin
            alu_op = 2'b01;
            if (branch_taken(funct3, zero)) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end else begin
              pc_write = 1'b0;
            end
            retire_s = 1'b1;
            estado_d = BUSCA;
          end
          default: estado_d = ERRO;
        endcase
      end
      MEMORIA: begin
        // opcode is held stable by the decoder, so it still selects load vs store here
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = (opcode == OP_STORE);
        end
        if (!mem_read && !mem_write) begin
          estado_d = ERRO;
        end else if (mem_ready) begin
          retire_s = mem_write;
          estado_d = mem_read ? ESCRITA : BUSCA;
        end else begin
          waiting_s = 1'b1;
          estado_d  = (wait_q == WAIT_LAST) ? ERRO : MEMORIA;
        end
      end
      ESCRITA: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        retire_s   = 1'b1;
        estado_d   = BUSCA;
      end
      ERRO:    estado_d = ERRO;
      default: estado_d = ERRO;
    endcase

    if (estado_d != estado_q) begin
      wait_d = '0;
    end else if (waiting_s) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
    count_d = retire_s ? count_q + CNT_W'(1) : count_q;
    erro_d  = erro_q | (estado_d == ERRO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= BUSCA;
      wait_q   <= '0;
      count_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      erro_q   <= erro_d;
    end
  end

  assign estado      = estado_q;
  assign instr_count = count_q;
  assign erro        = erro_q;

endmodule
